// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor, WIDTH bits in SEG-bit segments.
// Stage k resolves segment k by choosing between its two precomputed carry
// hypotheses using the carry registered by stage k-1. Operand segments not
// yet resolved ride along in skew registers; resolved segments travel forward.
// A single advance signal stalls the whole pipe when the consumer is not ready.
module pipelined_csel_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OV
);

  localparam int NSEG = WIDTH / SEG;

  // Operand skew registers; the last stage never needs raw operands again,
  // so only stages 0..NSEG-2 keep them.
  logic [WIDTH-1:0] a_r     [NSEG-1];
  logic [WIDTH-1:0] bx_r    [NSEG-1];
  // Partially resolved result, segment carry and valid for every stage.
  logic [WIDTH-1:0] y_r     [NSEG];
  logic             c_r     [NSEG];
  logic             valid_r [NSEG];
  logic             ov_r;

  // What each stage sees on its input side.
  logic [WIDTH-1:0] src_a_s  [NSEG];
  logic [WIDTH-1:0] src_bx_s [NSEG];
  logic [WIDTH-1:0] src_y_s  [NSEG];
  logic             src_c_s  [NSEG];
  logic             src_v_s  [NSEG];

  // Both carry hypotheses per segment and the selected one.
  logic [SEG:0]     sum0_s   [NSEG];
  logic [SEG:0]     sum1_s   [NSEG];
  logic [SEG:0]     sel_s    [NSEG];
  logic [WIDTH-1:0] nxt_y_s  [NSEG];
  logic             nxt_c_s  [NSEG];
  logic             nxt_ov_s;
  logic             adv_s;

  // The pipe moves whenever the output slot is empty or being taken.
  assign adv_s     = !valid_r[NSEG-1] || OUT_READY;
  assign IN_READY  = adv_s;
  assign OUT_VALID = valid_r[NSEG-1];
  assign Y         = y_r[NSEG-1];
  assign CO        = c_r[NSEG-1];
  assign OV        = ov_r;

  // Route inputs to each stage: stage 0 takes the pre-processed operand word.
  always_comb begin
    src_a_s[0]  = A;
    src_bx_s[0] = SUB ? ~B : B;
    src_c_s[0]  = SUB ? 1'b1 : CI;
    src_y_s[0]  = {WIDTH{1'b0}};
    src_v_s[0]  = IN_VALID;
    for (int k = 1; k < NSEG; k++) begin
      src_a_s[k]  = a_r[k-1];
      src_bx_s[k] = bx_r[k-1];
      src_c_s[k]  = c_r[k-1];
      src_y_s[k]  = y_r[k-1];
      src_v_s[k]  = valid_r[k-1];
    end
  end

  // Per-stage carry-select: form both hypotheses, pick by incoming carry.
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      sum0_s[k] = {1'b0, src_a_s[k][k*SEG +: SEG]} + {1'b0, src_bx_s[k][k*SEG +: SEG]};
      sum1_s[k] = {1'b0, src_a_s[k][k*SEG +: SEG]} + {1'b0, src_bx_s[k][k*SEG +: SEG]}
                  + {{SEG{1'b0}}, 1'b1};
      if (src_c_s[k]) begin
        sel_s[k] = sum1_s[k];
      end else begin
        sel_s[k] = sum0_s[k];
      end
      nxt_y_s[k]                 = src_y_s[k];
      nxt_y_s[k][k*SEG +: SEG]   = sel_s[k][SEG-1:0];
      nxt_c_s[k]                 = sel_s[k][SEG];
    end
    // Carry into the MSB is recovered from the MSB's sum bit and operands.
    nxt_ov_s = nxt_c_s[NSEG-1] ^ (src_a_s[NSEG-1][WIDTH-1] ^ src_bx_s[NSEG-1][WIDTH-1]
                                  ^ nxt_y_s[NSEG-1][WIDTH-1]);
  end

  // Pipeline registers: clear on reset, load all stages together on advance, else hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NSEG - 1; k++) begin
        a_r[k]  <= {WIDTH{1'b0}};
        bx_r[k] <= {WIDTH{1'b0}};
      end
      for (int k = 0; k < NSEG; k++) begin
        y_r[k]     <= {WIDTH{1'b0}};
        c_r[k]     <= 1'b0;
        valid_r[k] <= 1'b0;
      end
      ov_r <= 1'b0;
    end else if (adv_s) begin
      for (int k = 0; k < NSEG - 1; k++) begin
        a_r[k]  <= src_a_s[k];
        bx_r[k] <= src_bx_s[k];
      end
      for (int k = 0; k < NSEG; k++) begin
        y_r[k]     <= nxt_y_s[k];
        c_r[k]     <= nxt_c_s[k];
        valid_r[k] <= src_v_s[k];
      end
      ov_r <= nxt_ov_s;
    end
  end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder: directed scenarios on a
// 16/4 instance plus a random regression on 16/4 and 32/8 instances, with
// queue scoreboards fed at accept and drained at output retire.
module tb_pipelined_csel_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        in_valid16, in_ready16, ci16, sub16, out_valid16, out_ready16, co16, ovf16;
  logic [15:0] a16, b16, y16;
  logic        in_valid32, in_ready32, ci32, sub32, out_valid32, out_ready32, co32, ovf32;
  logic [31:0] a32, b32, y32;

  int total = 0;
  int bad = 0;
  int retired16 = 0;
  int retired32 = 0;
  logic [33:0] q16[$];
  logic [33:0] q32[$];

  pipelined_csel_adder #(.WIDTH(16), .SEG(4)) dut16 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid16), .IN_READY(in_ready16),
    .A(a16), .B(b16), .CI(ci16), .SUB(sub16),
    .OUT_VALID(out_valid16), .OUT_READY(out_ready16), .Y(y16), .CO(co16), .OV(ovf16)
  );

  pipelined_csel_adder #(.WIDTH(32), .SEG(8)) dut32 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid32), .IN_READY(in_ready32),
    .A(a32), .B(b32), .CI(ci32), .SUB(sub32),
    .OUT_VALID(out_valid32), .OUT_READY(out_ready32), .Y(y32), .CO(co32), .OV(ovf32)
  );

  // Reference: wide integer add, signed overflow from operand/result signs.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic sub, input int w);
    logic [63:0] mask, am, bx, sum;
    logic [31:0] y;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'd0, a} & mask;
    bx   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
    sum  = am + bx + {63'd0, (sub ? 1'b1 : ci)};
    y    = sum[31:0] & mask[31:0];
    co   = sum[w];
    ov   = (am[w-1] == bx[w-1]) && (y[w-1] != am[w-1]);
    return {ov, co, y};
  endfunction

  logic [33:0] exp16, got16, exp32, got32;

  // Scoreboard for the 16-bit instance: pop on retire, push on accept.
  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
    end else begin
      if (out_valid16 && out_ready16) begin
        total++;
        retired16++;
        got16 = {ovf16, co16, 16'd0, y16};
        if (q16.size() == 0) begin
          bad++;
          $display("FAIL sb16_unexpected: got y=%h co=%b ov=%b with no word outstanding", y16, co16, ovf16);
        end else begin
          exp16 = q16.pop_front();
          if (got16 !== exp16) begin
            bad++;
            $display("FAIL sb16_result: got ov,co,y=%h expected %h", got16, exp16);
          end
        end
      end
      if (in_valid16 && in_ready16)
        q16.push_back(ref_add({16'd0, a16}, {16'd0, b16}, ci16, sub16, 16));
    end
  end

  // Scoreboard for the 32-bit instance.
  always @(negedge clk) begin
    if (rst) begin
      q32.delete();
    end else begin
      if (out_valid32 && out_ready32) begin
        total++;
        retired32++;
        got32 = {ovf32, co32, y32};
        if (q32.size() == 0) begin
          bad++;
          $display("FAIL sb32_unexpected: got y=%h co=%b ov=%b with no word outstanding", y32, co32, ovf32);
        end else begin
          exp32 = q32.pop_front();
          if (got32 !== exp32) begin
            bad++;
            $display("FAIL sb32_result: got ov,co,y=%h expected %h", got32, exp32);
          end
        end
      end
      if (in_valid32 && in_ready32)
        q32.push_back(ref_add(a32, b32, ci32, sub32, 32));
    end
  end

  task automatic idle(input int n);
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    in_valid32 = 1'b0; out_ready32 = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one word into an empty 16-bit pipe and return the first result seen.
  task automatic send_and_get(input logic [15:0] a, input logic [15:0] b, input logic ci,
                              input logic sub, output logic [15:0] y, output logic co,
                              output logic ov, output logic ok);
    @(posedge clk); #1;
    a16 = a; b16 = b; ci16 = ci; sub16 = sub;
    in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid16) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    y = y16; co = co16; ov = ovf16;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid16 !== 1'b0 || y16 !== 16'h0000 || co16 !== 1'b0 || ovf16 !== 1'b0) begin
      bad++;
      $display("FAIL reset16: got v=%b y=%h co=%b ov=%b expected all zero", out_valid16, y16, co16, ovf16);
    end
    total++;
    if (out_valid32 !== 1'b0 || y32 !== 32'h0 || co32 !== 1'b0 || ovf32 !== 1'b0) begin
      bad++;
      $display("FAIL reset32: got v=%b y=%h co=%b ov=%b expected all zero", out_valid32, y32, co32, ovf32);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready16 !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready16);
    end
  endtask

  task automatic test_fill;
    @(posedge clk); #1;
    a16 = 16'h00FF; b16 = 16'h0001; ci16 = 1'b0; sub16 = 1'b0;
    in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid16 !== 1'b0) begin
        bad++;
        $display("FAIL fill_early: got out_valid=1 only %0d edges after accept, expected 0", i);
      end
      @(posedge clk); #1;
    end
    total++;
    if (out_valid16 !== 1'b1 || y16 !== 16'h0100 || co16 !== 1'b0 || ovf16 !== 1'b0) begin
      bad++;
      $display("FAIL fill_result: got v=%b y=%h co=%b ov=%b expected v=1 y=0100 co=0 ov=0",
               out_valid16, y16, co16, ovf16);
    end
    idle(6);
  endtask

  task automatic test_carry_chain;
    logic [15:0] y; logic co, ov, ok;
    send_and_get(16'hFFFF, 16'h0000, 1'b1, 1'b0, y, co, ov, ok);
    total++;
    if (ok !== 1'b1 || y !== 16'h0000 || co !== 1'b1 || ov !== 1'b0) begin
      bad++;
      $display("FAIL carry_chain: got ok=%b y=%h co=%b ov=%b expected ok=1 y=0000 co=1 ov=0", ok, y, co, ov);
    end
    idle(6);
  endtask

  task automatic test_sub_overflow;
    logic [15:0] y; logic co, ov, ok;
    send_and_get(16'h0003, 16'h0005, 1'b1, 1'b1, y, co, ov, ok);
    total++;
    if (ok !== 1'b1 || y !== 16'hFFFE || co !== 1'b0 || ov !== 1'b0) begin
      bad++;
      $display("FAIL sub_borrow: got ok=%b y=%h co=%b ov=%b expected ok=1 y=fffe co=0 ov=0", ok, y, co, ov);
    end
    idle(6);
    send_and_get(16'h7FFF, 16'h0001, 1'b0, 1'b0, y, co, ov, ok);
    total++;
    if (ok !== 1'b1 || y !== 16'h8000 || co !== 1'b0 || ov !== 1'b1) begin
      bad++;
      $display("FAIL add_ovf: got ok=%b y=%h co=%b ov=%b expected ok=1 y=8000 co=0 ov=1", ok, y, co, ov);
    end
    idle(6);
    send_and_get(16'h8000, 16'h0001, 1'b0, 1'b1, y, co, ov, ok);
    total++;
    if (ok !== 1'b1 || y !== 16'h7FFF || co !== 1'b1 || ov !== 1'b1) begin
      bad++;
      $display("FAIL sub_ovf: got ok=%b y=%h co=%b ov=%b expected ok=1 y=7fff co=1 ov=1", ok, y, co, ov);
    end
    idle(6);
  endtask

  task automatic test_back_pressure;
    int sent = 0;
    int r0 = retired16;
    int stall_left = 0;
    logic stall_done = 1'b0;
    logic [15:0] held = 16'h0000;
    logic [15:0] idx;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (!stall_done && stall_left == 0 && out_valid16) begin
        stall_left = 3;
        held = y16;
      end
      out_ready16 = (stall_left > 0) ? 1'b0 : 1'b1;
      if (sent < 6) begin
        idx = 16'(sent);
        in_valid16 = 1'b1;
        a16 = 16'h1111 * (idx + 16'd1);
        b16 = 16'h0123 + idx;
        ci16 = idx[1];
        sub16 = idx[0];
      end else begin
        in_valid16 = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        total++;
        if (in_ready16 !== 1'b0 || out_valid16 !== 1'b1 || y16 !== held) begin
          bad++;
          $display("FAIL stall_hold: got in_ready=%b v=%b y=%h expected in_ready=0 v=1 y=%h",
                   in_ready16, out_valid16, y16, held);
        end
        stall_left--;
        if (stall_left == 0) stall_done = 1'b1;
      end
      @(negedge clk);
      if (in_valid16 && in_ready16) sent++;
      @(posedge clk); #1;
      if (sent == 6 && retired16 - r0 == 6) break;
    end
    idle(8);
    total++;
    if (sent != 6 || retired16 - r0 != 6 || q16.size() != 0 || !stall_done) begin
      bad++;
      $display("FAIL bp_count: got sent=%0d retired=%0d pending=%0d stalled=%b expected 6 6 0 1",
               sent, retired16 - r0, q16.size(), stall_done);
    end
  endtask

  task automatic test_bubbles;
    logic [7:0] pat = 8'b0101_0101;
    logic exp_v;
    @(posedge clk); #1;
    out_ready16 = 1'b1;
    for (int j = 0; j < 12; j++) begin
      exp_v = (j >= 4) ? pat[j-4] : 1'b0;
      total++;
      if (out_valid16 !== exp_v) begin
        bad++;
        $display("FAIL bubble_pattern: cycle %0d got out_valid=%b expected %b", j, out_valid16, exp_v);
      end
      in_valid16 = (j < 8) ? pat[j] : 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom);
      ci16 = 1'($urandom_range(1, 0)); sub16 = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
    end
    idle(6);
  endtask

  task automatic test_mid_reset;
    int seen = 0;
    @(posedge clk); #1;
    out_ready16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid16 = 1'b1;
      a16 = 16'hA000 + 16'(i); b16 = 16'h0F0F; ci16 = 1'b0; sub16 = 1'b0;
      @(posedge clk); #1;
    end
    in_valid16 = 1'b0;
    total++;
    if (out_valid16 !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre: got out_valid=%b expected 1", out_valid16);
    end
    rst = 1'b1;
    #1;
    total++;
    if (out_valid16 !== 1'b0) begin
      bad++;
      $display("FAIL midreset_now: got out_valid=%b expected 0", out_valid16);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid16) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_leak: got %0d stale outputs expected 0", seen);
    end
  endtask

  task automatic test_random;
    int n = 10000;
    int sent16 = 0;
    int sent32 = 0;
    logic pend16 = 1'b0;
    logic pend32 = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 60000 && (sent16 < n || sent32 < n); cyc++) begin
      out_ready16 = ($urandom_range(3, 0) != 0);
      out_ready32 = ($urandom_range(3, 0) != 0);
      if (!pend16 && sent16 < n && $urandom_range(3, 0) != 0) begin
        pend16 = 1'b1;
        a16 = 16'($urandom); b16 = 16'($urandom);
        ci16 = 1'($urandom_range(1, 0)); sub16 = 1'($urandom_range(1, 0));
      end
      if (!pend32 && sent32 < n && $urandom_range(3, 0) != 0) begin
        pend32 = 1'b1;
        a32 = $urandom; b32 = $urandom;
        ci32 = 1'($urandom_range(1, 0)); sub32 = 1'($urandom_range(1, 0));
      end
      in_valid16 = pend16;
      in_valid32 = pend32;
      @(negedge clk);
      if (in_valid16 && in_ready16) begin pend16 = 1'b0; sent16++; end
      if (in_valid32 && in_ready32) begin pend32 = 1'b0; sent32++; end
      @(posedge clk); #1;
    end
    idle(20);
    total++;
    if (sent16 != n || q16.size() != 0) begin
      bad++;
      $display("FAIL rand16_drain: got sent=%0d pending=%0d expected %0d 0", sent16, q16.size(), n);
    end
    total++;
    if (sent32 != n || q32.size() != 0) begin
      bad++;
      $display("FAIL rand32_drain: got sent=%0d pending=%0d expected %0d 0", sent32, q32.size(), n);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = 16'h0; b16 = 16'h0; ci16 = 1'b0; sub16 = 1'b0;
    in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = 32'h0; b32 = 32'h0; ci32 = 1'b0; sub32 = 1'b0;
    test_reset;
    test_fill;
    test_carry_chain;
    test_sub_overflow;
    test_back_pressure;
    test_bubbles;
    test_mid_reset;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_csel_adder.md
# pipelined_csel_adder

Parametrised, pipelined carry-select adder/subtractor with a valid/ready handshake. It generalises the team's fixed 8-bit carry-select adder to WIDTH bits split into SEG-bit segments. Each segment computes both carry hypotheses and resolves its select in its own pipeline stage, so throughput is one operation per clock. It sits between operand registers and the result bus of the datapath and can be stalled by its consumer.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG, minimum 2·SEG.
- SEG, 4, segment width in bits; NSEG = WIDTH/SEG pipeline stages.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operand word present on A, B, CI, SUB.
- IN_READY  output  1  block accepts the operand word this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CI  input  1  carry in; used only when SUB=0.
- SUB  input  1  0: Y = A + B + CI; 1: Y = A + ~B + 1 (A − B); CI ignored.
- OUT_VALID  output  1  Y, CO and OV hold a result.
- OUT_READY  input  1  consumer takes the result this cycle.
- Y  output  WIDTH  sum/difference, modulo 2^WIDTH.
- CO  output  1  carry out of the MSB; for SUB=1, CO=1 means no borrow (A ≥ B unsigned).
- OV  output  1  two's-complement signed overflow.

## Operation
- Accept: a word transfers when IN_VALID && IN_READY.
- Pre-processing at accept: Bx = SUB ? ~B : B; c0 = SUB ? 1 : CI.
- Stage k (k = 0..NSEG−1) owns segment k, bits [k·SEG +: SEG].
  - It forms s0 = Ak + Bxk + 0 and s1 = Ak + Bxk + 1, each SEG+1 bits wide.
  - It selects by the carry registered from stage k−1; stage 0 uses c0.
  - It writes the selected SEG sum bits and the selected carry into its pipeline register.
- Segments above k travel unmodified (A, Bx skew registers). Resolved low segments travel forward. Each stage carries one valid bit.
- Final stage outputs:
  - Y is the concatenated resolved segments.
  - CO is the carry out of segment NSEG−1.
  - OV = carry into MSB XOR carry out of MSB.
- Arithmetic is exact modulo 2^WIDTH. There is no saturation.
- Stall rule: one global advance signal, adv = !OUT_VALID || OUT_READY.
  - When adv=1, every stage register loads from its predecessor.
  - Stage 0 loads the accepted word, or a bubble (valid=0) when nothing is accepted.
  - When adv=0, every stage register, including data and valid, holds.
- IN_READY = adv, combinational from OUT_VALID and OUT_READY.
- Bubbles propagate as valid=0. Data registers of a bubble stage may hold stale values. The outputs Y, CO and OV are only meaningful while OUT_VALID=1.

## Timing
- Reset (RST=1, asynchronous):
  - All stage valid bits become 0.
  - OUT_VALID=0, Y=0, CO=0, OV=0.
  - IN_READY=1 as soon as RST deasserts.
- Reset mid-operation: all in-flight words are discarded immediately. No result from before reset ever appears on the output.
- Latency: a word accepted at edge n appears with OUT_VALID=1 after edge n+NSEG−1. That is NSEG cycles of register delay: 4 for the defaults.
- Throughput: one word per cycle while OUT_READY=1.
- Output stability: while OUT_VALID=1 and OUT_READY=0, Y, CO and OV are held stable and IN_READY=0. The upstream must hold its word until it is accepted.
- Same-cycle events: when OUT_READY=1 with a full pipe, the output word retires and a new input is accepted in the same cycle. There is no bubble and no loss.
- Empty pipe: when OUT_VALID=0, IN_READY=1 regardless of OUT_READY.
- There are no combinational paths from A, B, CI or SUB to any output.

## Test plan
- Reset and fill (WIDTH=16, SEG=4):
  - Stimulus: RST pulse; then A=16'h00FF, B=16'h0001, CI=0, SUB=0, one cycle, OUT_READY=1.
  - Response: OUT_VALID rises 4 edges after accept with Y=16'h0100, CO=0, OV=0. All outputs are 0 during reset.
- Full carry chain:
  - Stimulus: A=16'hFFFF, B=16'h0000, CI=1.
  - Response: Y=16'h0000, CO=1, OV=0. The carry propagates through every stage.
- Subtract and overflow:
  - Stimulus: A=16'h0003, B=16'h0005, SUB=1.
  - Response: Y=16'hFFFE, CO=0.
  - Stimulus: A=16'h7FFF, B=16'h0001, SUB=0, CI=0.
  - Response: Y=16'h8000, OV=1.
  - Stimulus: A=16'h8000, B=16'h0001, SUB=1.
  - Response: Y=16'h7FFF, OV=1, CO=1.
- Back-pressure:
  - Stimulus: stream 6 distinct words with OUT_READY=1; drop OUT_READY to 0 for 3 cycles once the first result appears.
  - Response: IN_READY=0 and Y held constant for those 3 cycles. All 6 results arrive in order with no loss and no duplicates.
- Bubbles and mid-stream reset:
  - Stimulus: alternate IN_VALID 1/0 across 4 words.
  - Response: OUT_VALID shows the same 1/0 pattern, delayed by 4 cycles.
  - Stimulus: assert RST while 3 words are in flight.
  - Response: OUT_VALID=0 at once, and none of the 3 words ever emerges.
- Random regression:
  - Stimulus: 10k random A, B, CI, SUB with random OUT_READY, at WIDTH=16/SEG=4 and WIDTH=32/SEG=8.
  - Response: every result matches the reference model for Y, CO and OV, in order.
